// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    // Start bit is re-sampled at its centre, half a bit period after the falling edge.
    function automatic int unsigned half_bit(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_c,
    output logic                   empty_c,
    output logic                   drop_c,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             full;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign head_c  = mem[rptr];
    assign rd_ok   = pop && !empty_c;
    assign wr_ok   = push && (!full || rd_ok);
    assign drop_c  = push && full && !rd_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[wptr] <= din;
                wptr      <= wptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CNT_W'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver: synchroniser, 8N1 deframer and byte FIFO presented as a valid/ready stream.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits (8E1).
module uart_rx_stream
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic [UART_DATA_W-1:0]      m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overrun,
    output logic                        parity_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(UART_DATA_W);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(UART_DATA_W - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    uart_state_e            state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [BIT_W-1:0]       bitcnt, bitcnt_d;
    logic [UART_DATA_W-1:0] shreg, shreg_d;
    logic                   push_r, push_d;
    logic                   frame_err_d;
    logic                   parity_err_d;
    logic                   bit_done;
    logic                   pop;
    logic                   empty_c;
    logic                   drop_c;

    assign rx_s     = sync[SYNC_STAGES-1];
    assign bit_done = (cnt == BIT_LAST);
    assign m_valid  = !empty_c;
    assign pop      = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= '1;
            state      <= IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            push_r     <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], rx};
            state      <= state_d;
            cnt        <= cnt_d;
            bitcnt     <= bitcnt_d;
            shreg      <= shreg_d;
            push_r     <= push_d;
            frame_err  <= frame_err_d;
            parity_err <= parity_err_d;
            overrun    <= drop_c;
        end
    end

    // Baud counter restarts from zero on every state change and after every data sample.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt + CNT_W'(1);
        bitcnt_d     = bitcnt;
        shreg_d      = shreg;
        push_d       = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    bitcnt_d = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d    = '0;
                    shreg_d  = {rx_s, shreg[UART_DATA_W-1:1]};
                    bitcnt_d = bitcnt + BIT_W'(1);
                    if (bitcnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_d        = '0;
                    parity_err_d = (rx_s != ^shreg);
                    state_d      = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // shreg is stable for at least half a bit after the stop sample, so it feeds the FIFO directly.
    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_r),
        .din     (shreg),
        .pop     (pop),
        .head_c  (m_data),
        .empty_c (empty_c),
        .drop_c  (drop_c),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_stream.sv
// Bench for uart_rx_stream: serial frames built from bit lists, bytes scoreboarded against pops.
`timescale 1ns/1ps
module tb_uart_rx_stream;

    localparam int unsigned CPB    = 104;
    localparam int unsigned DEPTH  = 16;
    localparam int          CLK_NS = 84;
    localparam int          BIT_NS = CLK_NS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [4:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         exp_fe = 0, exp_ov = 0, exp_pe = 0;
    int         obs_fe = 0, obs_ov = 0, obs_pe = 0;
    int         ready_mode = 0;

    uart_rx_stream #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #(CLK_NS/2) clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_flags(input string name);
        check({name, "_frame_err"}, obs_fe, exp_fe);
        check({name, "_overrun"}, obs_ov, exp_ov);
        check({name, "_parity_err"}, obs_pe, exp_pe);
    endtask

    task automatic wait_empty(input string name);
        int k = 0;
        while (m_valid && k < 200) begin
            hold(1);
            k++;
        end
        check(name, int'(m_valid), 0);
    endtask

    // A received byte is expected unless the FIFO already holds DEPTH unread bytes.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int stop_bits,
                              input bit bad_par);
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ bad_par;
        if (bad_par) exp_pe++;
        hold(CPB);
`else
        if (bad_par) rx = 1'b1;
`endif
        if (stop_ok) begin
            if (exp_q.size() >= DEPTH) exp_ov++;
            else exp_q.push_back(b);
            rx = 1'b1;
            hold(CPB * stop_bits);
        end else begin
            exp_fe++;
            rx = 1'b0;
            hold(CPB * stop_bits);
            rx = 1'b1;
            hold(10);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ($urandom_range(0, 1) == 1);
        endcase
    end

    // Monitor: a pop happens at the next rising edge whenever valid and ready are both high now.
    always @(negedge clk) begin
        if (frame_err)  obs_fe++;
        if (overrun)    obs_ov++;
        if (parity_err) obs_pe++;
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) check("unexpected_pop", int'(m_data), -1);
            else check("pop_data", int'(m_data), int'(exp_q.pop_front()));
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0;
        int     k;
        rst = 1'b1;
        rx  = 1'b1;
        hold(5);
        check("rst_valid", int'(m_valid), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_data", int'(m_data), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_parity_err", int'(parity_err), 0);
        rst = 1'b0;
        hold(5);

        // T1: single frame with the consumer stalled
        while ($time < 100_000) @(negedge clk);
        t0 = $time;
        send_frame(8'hAA, 1'b1, 1, 1'b0);
        k = 0;
        while (!m_valid && k < 4) begin
            hold(1);
            k++;
        end
        check("t1_valid", int'(m_valid), 1);
        check("t1_latency", int'(($time - t0) <= longint'(10 * BIT_NS + 4 * CLK_NS)), 1);
        check("t1_data", int'(m_data), 'hAA);
        check("t1_count", int'(fifo_count), 1);
        check_flags("t1");
        ready_mode = 1;
        wait_empty("t1_drain");

        // T2: back-to-back frames, consumer always ready
        send_frame(8'h55, 1'b1, 1, 1'b0);
        send_frame(8'hFF, 1'b1, 1, 1'b0);
        hold(10);
        wait_empty("t2_drain");
        check("t2_count", int'(fifo_count), 0);
        check("t2_all_popped", exp_q.size(), 0);

        // T3: short low glitch
        rx = 1'b0;
        hold(20);
        rx = 1'b1;
        hold(100);
        check("t3_state_idle", int'(dut.state), int'(uart_pkg::IDLE));
        check("t3_count", int'(fifo_count), 0);
        check_flags("t3");

        // T4: stop bit held low for two bit times, then a good frame
        send_frame(8'h3C, 1'b0, 2, 1'b0);
        hold(20);
        send_frame(8'h81, 1'b1, 1, 1'b0);
        hold(10);
        wait_empty("t4_drain");
        check_flags("t4");

        // T5: 17 frames into a stalled consumer
        ready_mode = 0;
        hold(2);
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1, 1'b0);
        hold(5);
        check("t5_count_full", int'(fifo_count), DEPTH);
        check_flags("t5");
        ready_mode = 1;
        hold(2);
        wait_empty("t5_drain");
        check("t5_count_empty", int'(fifo_count), 0);

        // T6: reset during bit 4 of 0xC3, then a clean 0x7E
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = ((8'hC3 >> i) & 8'h01) != 0;
            hold(CPB);
        end
        rx = 1'b0;
        hold(CPB / 2);
        rst = 1'b1;
        rx  = 1'b1;
        hold(3);
        rst = 1'b0;
        hold(300);
        check("t6_count_after_rst", int'(fifo_count), 0);
        send_frame(8'h7E, 1'b1, 1, 1'b0);
`ifdef UART_RX_PARITY_EN
        send_frame(8'h7E, 1'b1, 1, 1'b1);
`endif
        hold(10);
        wait_empty("t6_drain");
        check_flags("t6");

        // Randomised traffic with a randomly stalling consumer
        ready_mode = 2;
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                rx = 1'b0;
                hold(int'($urandom_range(1, 40)));
                rx = 1'b1;
                hold(80);
            end else begin
                bit ok;
                ok = ($urandom_range(0, 5) != 0);
                send_frame(8'($urandom_range(0, 255)), ok, ok ? 1 : int'($urandom_range(1, 2)),
                           $urandom_range(0, 3) == 0);
            end
            hold(int'($urandom_range(0, 20)));
        end
        ready_mode = 1;
        hold(CPB);
        wait_empty("rand_drain");
        check("rand_all_popped", exp_q.size(), 0);
        check_flags("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
